// File: rtl/d_bch_par_encoder.sv
// Parallel BCH systematic encoder: consumes PAR message bits per beat,
// then streams the PRT_LEN-bit remainder out PAR bits per beat, MSB first.
module d_bch_par_encoder #(
    parameter int PRT_LEN = 168,
    parameter int PAR = 8,
    parameter int MSG_BITS = 4096,
    // Bit i is the coefficient of x^i. The integrating top normally overrides
    // this with the code's generator; the default only pins both end terms.
    parameter logic [PRT_LEN:0] G_POLY = {1'b1, {(PRT_LEN-1){1'b0}}, 1'b1}
) (
    input  logic           i_clk,
    input  logic           i_RESET,
    input  logic           i_msg_valid,
    input  logic [PAR-1:0] i_msg_data,
    output logic           o_msg_ready,
    output logic           o_prt_valid,
    output logic [PAR-1:0] o_prt_data,
    output logic           o_prt_last,
    input  logic           i_prt_ready,
    output logic           o_busy
);

    localparam int NB = MSG_BITS / PAR;
    localparam int NP = PRT_LEN / PAR;
    localparam int MAXB = (NB > NP) ? NB : NP;
    localparam int CW = $clog2(MAXB + 1);
    localparam logic [CW-1:0] NB_LAST = CW'(NB - 1);
    localparam logic [CW-1:0] NP_LAST = CW'(NP - 1);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PRT
    } state_t;

    state_t              state_q, state_d;
    logic [PRT_LEN-1:0]  r_q, r_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    // PAR serial LFSR division steps unrolled into one combinational update
    function automatic logic [PRT_LEN-1:0] div_step(
        input logic [PRT_LEN-1:0] rem,
        input logic [PAR-1:0]     d
    );
        logic [PRT_LEN-1:0] acc;
        logic               fb;
        acc = rem;
        for (int k = PAR - 1; k >= 0; k--) begin
            fb  = d[k] ^ acc[PRT_LEN-1];
            acc = (acc << 1) ^ (fb ? G_POLY[PRT_LEN-1:0] : '0);
        end
        return acc;
    endfunction

    assign o_msg_ready = (state_q != PRT);
    assign o_prt_valid = (state_q == PRT);
    assign o_prt_data  = o_prt_valid ? r_q[PRT_LEN-1 -: PAR] : '0;
    assign o_prt_last  = o_prt_valid && (cnt_q == NP_LAST);
    assign o_busy      = (state_q != IDLE);

    // Next-state: absorb message beats, then shift parity out under handshake
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_msg_valid) begin
                    r_d = div_step('0, i_msg_data);
                    if (NB == 1) begin
                        state_d = PRT;
                        cnt_d   = '0;
                    end else begin
                        state_d = MSG;
                        cnt_d   = CW'(1);
                    end
                end
            end
            MSG: begin
                if (i_msg_valid) begin
                    r_d = div_step(r_q, i_msg_data);
                    if (cnt_q == NB_LAST) begin
                        state_d = PRT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PRT: begin
                if (i_prt_ready) begin
                    if (cnt_q == NP_LAST) begin
                        state_d = IDLE;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        r_d   = r_q << PAR;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                r_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, remainder and beat counter registers
    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_d_bch_par_encoder.sv
// Scoreboard bench for d_bch_par_encoder with a small x^4+x+1 code.
// Expected parity is pushed by the driver and popped by a monitor.
module tb_d_bch_par_encoder;

    localparam int PL = 4;
    localparam int P = 2;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         i_RESET;
    logic         i_msg_valid;
    logic [P-1:0] i_msg_data;
    logic         o_msg_ready;
    logic         o_prt_valid;
    logic [P-1:0] o_prt_data;
    logic         o_prt_last;
    logic         i_prt_ready;
    logic         o_busy;

    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    d_bch_par_encoder #(
        .PRT_LEN(PL),
        .PAR(P),
        .MSG_BITS(MB),
        .G_POLY(5'b10011)
    ) dut (
        .i_clk(clk),
        .i_RESET(i_RESET),
        .i_msg_valid(i_msg_valid),
        .i_msg_data(i_msg_data),
        .o_msg_ready(o_msg_ready),
        .o_prt_valid(o_prt_valid),
        .o_prt_data(o_prt_data),
        .o_prt_last(o_prt_last),
        .i_prt_ready(i_prt_ready),
        .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_par(input logic [1:0] p0, input logic [1:0] p1);
        exp_q.push_back({1'b0, p0});
        exp_q.push_back({1'b1, p1});
    endtask

    task automatic beat(input logic [1:0] b, output int waited);
        waited = 0;
        i_msg_valid = 1'b1;
        i_msg_data = b;
        @(negedge clk);
        while (!o_msg_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        chk("msg_ready_wait", o_msg_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(name, o_busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted parity beat against the scoreboard
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (!i_RESET && o_prt_valid && i_prt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL prt_unexpected: got %0h expected none",
                             o_prt_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("prt_data", o_prt_data, e[1:0]);
                    chk("prt_last", o_prt_last, e[2]);
                end
            end
        end
    end

    initial begin
        int w;
        i_RESET = 1'b1;
        i_msg_valid = 1'b0;
        i_msg_data = '0;
        i_prt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_msg_ready", o_msg_ready, 1);
        chk("rst_prt_valid", o_prt_valid, 0);
        chk("rst_prt_last", o_prt_last, 0);
        chk("rst_prt_data", o_prt_data, 0);
        chk("rst_busy", o_busy, 0);
        i_RESET = 1'b0;

        // 10,00 -> 10,11 with one cycle latency
        expect_par(2'b10, 2'b11);
        beat(2'b10, w);
        beat(2'b00, w);
        i_msg_valid = 1'b0;
        chk("latency_valid", o_prt_valid, 1);
        chk("prt_msg_ready", o_msg_ready, 0);
        wait_idle("idle1");

        // 00,01 -> 00,11
        expect_par(2'b00, 2'b11);
        beat(2'b00, w);
        beat(2'b01, w);
        i_msg_valid = 1'b0;
        wait_idle("idle2");

        // all-zero message
        expect_par(2'b00, 2'b00);
        beat(2'b00, w);
        beat(2'b00, w);
        i_msg_valid = 1'b0;
        wait_idle("zero_busy");

        // backpressure with junk message data offered during PRT
        i_prt_ready = 1'b0;
        expect_par(2'b10, 2'b11);
        beat(2'b10, w);
        beat(2'b00, w);
        i_msg_data = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", o_prt_data, 2'b10);
            chk("bp_valid", o_prt_valid, 1);
            chk("bp_last", o_prt_last, 0);
            chk("bp_msg_ready", o_msg_ready, 0);
        end
        @(posedge clk);
        #1;
        i_msg_valid = 1'b0;
        i_prt_ready = 1'b1;
        wait_idle("idle_bp");

        // reset mid-message, then a clean message
        beat(2'b11, w);
        i_msg_valid = 1'b0;
        i_RESET = 1'b1;
        @(posedge clk);
        #1;
        i_RESET = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_msg_ready", o_msg_ready, 1);
        expect_par(2'b10, 2'b11);
        beat(2'b10, w);
        beat(2'b00, w);
        i_msg_valid = 1'b0;
        wait_idle("idle_rst");

        // back-to-back messages with valid held high
        expect_par(2'b10, 2'b11);
        expect_par(2'b00, 2'b11);
        beat(2'b10, w);
        beat(2'b00, w);
        beat(2'b00, w);
        chk("b2b_gap", w, 2);
        beat(2'b01, w);
        i_msg_valid = 1'b0;
        wait_idle("idle_b2b");

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d_bch_par_encoder.md
D_BCH_PAR_ENCODER -- requirements
Module: d_bch_par_encoder

Interface
REQ-001 SHALL have parameter PRT_LEN, default 168: parity length in bits; a multiple of PAR.
REQ-002 SHALL have parameter PAR, default 8: bits accepted and emitted per beat; 1 <= PAR <= PRT_LEN.
REQ-003 SHALL have parameter MSG_BITS, default 4096: message length in bits; a multiple of PAR.
REQ-004 SHALL have parameter G_POLY, width PRT_LEN+1, default the `D_BCH_ENC_G_POLY generator from d_BCH_encoder_parameters.vh re-ordered so that bit i is the coefficient of x^i; G_POLY[PRT_LEN] = G_POLY[0] = 1.
REQ-005 SHALL have port i_clk  input  1  clock, all logic rising-edge.
REQ-006 SHALL have port i_RESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_msg_valid  input  1  message beat valid.
REQ-008 SHALL have port i_msg_data  input  PAR  message beat; bit PAR-1 is the earliest, highest-order bit.
REQ-009 SHALL have port o_msg_ready  output  1  block accepts a message beat.
REQ-010 SHALL have port o_prt_valid  output  1  parity beat valid.
REQ-011 SHALL have port o_prt_data  output  PAR  parity beat, MSB-first.
REQ-012 SHALL have port o_prt_last  output  1  marks the final parity beat.
REQ-013 SHALL have port i_prt_ready  input  1  downstream accepts the parity beat.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, MSG and PRT.
REQ-016 SHALL define a message beat as accepted when i_msg_valid & o_msg_ready is high at a clock edge.
REQ-017 SHALL define a parity beat as accepted when o_prt_valid & i_prt_ready is high at a clock edge.
REQ-018 SHALL drive o_msg_ready = 1 in IDLE and MSG, and 0 in PRT.
REQ-019 SHALL update the PRT_LEN-bit remainder register r on each accepted message beat by applying, for k = PAR-1 down to 0, the step: fb = d[k] ^ r[PRT_LEN-1]; r = (r << 1) ^ (fb ? G_POLY[PRT_LEN-1:0] : 0). All PAR steps SHALL complete in one cycle.
REQ-020 SHALL, on the first accepted beat in IDLE, compute from r = 0, load a beat counter, and move to MSG; when MSG_BITS == PAR, it SHALL move directly to PRT.
REQ-021 SHALL count accepted beats and, on acceptance of beat MSG_BITS/PAR, move to PRT on the next edge with the final r.
REQ-022 SHALL leave r, the counters and the state unchanged while i_msg_valid is low in MSG (stall).
REQ-023 SHALL assert o_prt_valid for exactly the cycles spent in PRT.
REQ-024 SHALL drive o_prt_data = r[PRT_LEN-1 -: PAR] in PRT.
REQ-025 SHALL, on each accepted parity beat, shift r left by PAR with zero fill.
REQ-026 SHALL hold o_prt_data and o_prt_last stable while o_prt_valid & !i_prt_ready (backpressure).
REQ-027 SHALL assert o_prt_last only on parity beat PRT_LEN/PAR.
REQ-028 SHALL, on acceptance of the final parity beat, clear r, return to IDLE and raise o_msg_ready on the next cycle; the first beat of a new message can be accepted in that cycle.
REQ-029 SHALL leave the remainder computation unaffected by message data presented while o_msg_ready = 0.
REQ-030 SHALL produce parity such that codeword = message·x^PRT_LEN + parity is divisible by G_POLY.
REQ-031 SHALL have latency of 1 cycle from acceptance of the last message beat to the first o_prt_valid.

Reset
REQ-032 SHALL, while i_RESET is high at an edge, set state = IDLE, r = 0 and counters = 0; o_msg_ready = 1, o_prt_valid = 0, o_prt_last = 0, o_prt_data = 0, o_busy = 0.
REQ-033 SHALL, on reset asserted in MSG or PRT, abort the codeword; the next message after reset SHALL encode as if none preceded it.

Verification (PRT_LEN=4, PAR=2, MSG_BITS=4, G_POLY=5'b10011)
REQ-034 SHALL cover: beats 2'b10, 2'b00 with i_prt_ready=1 -> parity beats 2'b10, then 2'b11 with o_prt_last; first o_prt_valid one cycle after beat 2.
REQ-035 SHALL cover: beats 2'b00, 2'b01 -> parity beats 2'b00, 2'b11.
REQ-036 SHALL cover: an all-zero message -> parity beats 2'b00, 2'b00, and o_busy returns to 0 after the last beat.
REQ-037 SHALL cover: the first case with i_prt_ready held low 3 cycles -> o_prt_data stays 2'b10 and o_msg_ready stays 0 throughout.
REQ-038 SHALL cover: i_RESET pulsed after beat 1 of message 2'b11, 2'b11, then message 2'b10, 2'b00 -> parity 2'b10, 2'b11.
REQ-039 SHALL cover: back-to-back messages with constant i_msg_valid -> no gap beyond the PRT phase, and both parities correct.
